// File: rtl/quad_decoder.sv
// Quadrature encoder interface.
// Synchronises and glitch-filters the raw A/B/Z pins, decodes A/B at x1/x2/x4
// resolution into a wrapping position count, flags illegal (two-bit) transitions,
// handles index zeroing and reports signed net steps per fixed velocity window.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   inA/inB    raw encoder channels (asynchronous)
//   inZ        raw index channel (asynchronous)
//   clear      synchronous count / index_seen clear
//   err_clr    clears the sticky error flag
//   count      unsigned wrapping position
//   direction  0 = last valid step forward (A leads), 1 = reverse
//   step       one-cycle pulse per counted step
//   index_seen sticky filtered-Z rising edge flag
//   error      sticky illegal-transition flag
//   velocity   signed net steps in the last complete window
//   vel_valid  one-cycle pulse when velocity updates
module quad_decoder #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FILTER_LEN  = 50,
  parameter int unsigned MODE        = 2,
  parameter int unsigned INDEX_CLEAR = 1,
  parameter int unsigned VEL_WINDOW  = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inA,
  input  logic             inB,
  input  logic             inZ,
  input  logic             clear,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             direction,
  output logic             step,
  output logic             index_seen,
  output logic             error,
  output logic [WIDTH-1:0] velocity,
  output logic             vel_valid
);

  localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned WCW = $clog2(VEL_WINDOW);
  localparam int unsigned AW  = WIDTH + 1;

  // Channel order in the packed vectors: {A, B, Z}
  logic [2:0]          sync1_q, sync2_q, filt_q;
  logic [2:0][FCW-1:0] fcnt_q;

  logic [1:0]       ab_prev_q;
  logic             z_prev_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, step_q, index_q, error_q;
  logic [WIDTH-1:0] acc_q, acc_sat, velocity_q;
  logic             vel_valid_q;
  logic [WCW-1:0]   win_q;

  logic [1:0]  ab_cur, ab_diff;
  logic        valid, illegal, rev, counted, z_rise, win_end;
  logic [AW-1:0] step_ext, acc_sum;

  // Two-flop synchronisers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {inA, inB, inZ};
      sync2_q <= sync1_q;
    end
  end

  // Filtered level follows only after FILTER_LEN consecutive differing cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '0;
      fcnt_q <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (sync2_q[c] == filt_q[c]) begin
          fcnt_q[c] <= '0;
        end else if (fcnt_q[c] == FCW'(FILTER_LEN - 1)) begin
          filt_q[c] <= sync2_q[c];
          fcnt_q[c] <= '0;
        end else begin
          fcnt_q[c] <= fcnt_q[c] + 1'b1;
        end
      end
    end
  end

  // Decode
  always_comb begin
    ab_cur  = filt_q[2:1];
    ab_diff = ab_cur ^ ab_prev_q;
    valid   = (ab_diff == 2'b01) || (ab_diff == 2'b10);
    illegal = (ab_diff == 2'b11);
    // On the gray sequence 00-10-11-01, old A differs from new B only when stepping backwards
    rev     = ab_prev_q[1] ^ ab_cur[0];
    case (MODE)
      0:       counted = valid & ~ab_prev_q[1] & ab_cur[1];
      1:       counted = valid & ab_diff[1];
      default: counted = valid;
    endcase
    z_rise = filt_q[0] & ~z_prev_q;
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (z_rise && (INDEX_CLEAR == 1)) begin
      count_d = '0;
    end else if (counted) begin
      count_d = rev ? count_q - 1'b1 : count_q + 1'b1;
    end
  end

  // Saturating signed accumulator update, computed one bit wider to spot overflow
  always_comb begin
    step_ext = '0;
    if (counted) begin
      step_ext = rev ? {AW{1'b1}} : AW'(1);
    end
    acc_sum = {acc_q[WIDTH-1], acc_q} + step_ext;
    if (acc_sum[AW-1] != acc_sum[AW-2]) begin
      acc_sat = acc_sum[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      acc_sat = acc_sum[WIDTH-1:0];
    end
    win_end = (win_q == WCW'(VEL_WINDOW - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ab_prev_q <= 2'b00;
      z_prev_q  <= 1'b0;
      count_q   <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      index_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      ab_prev_q <= ab_cur;
      z_prev_q  <= filt_q[0];
      count_q   <= count_d;
      step_q    <= counted;
      if (valid) begin
        dir_q <= rev;
      end
      if (clear) begin
        index_q <= 1'b0;
      end else if (z_rise) begin
        index_q <= 1'b1;
      end
      // A same-cycle illegal transition beats err_clr
      if (illegal) begin
        error_q <= 1'b1;
      end else if (err_clr) begin
        error_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q       <= '0;
      acc_q       <= '0;
      velocity_q  <= '0;
      vel_valid_q <= 1'b0;
    end else if (win_end) begin
      win_q       <= '0;
      acc_q       <= '0;
      velocity_q  <= acc_sat;
      vel_valid_q <= 1'b1;
    end else begin
      win_q       <= win_q + 1'b1;
      acc_q       <= acc_sat;
      vel_valid_q <= 1'b0;
    end
  end

  assign count      = count_q;
  assign direction  = dir_q;
  assign step       = step_q;
  assign index_seen = index_q;
  assign error      = error_q;
  assign velocity   = velocity_q;
  assign vel_valid  = vel_valid_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: four instances share stimulus (x4, x2, x1 with index
// zeroing, and x4 without index zeroing), checked against a gray-position model.
module tb_quad_decoder;
  localparam int unsigned W  = 16;
  localparam int unsigned FL = 4;
  localparam int unsigned VW = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inA = 1'b0, inB = 1'b0, inZ = 1'b0, clear = 1'b0, err_clr = 1'b0;
  logic [3:0][W-1:0] cnt_o, vel_o;
  logic [3:0]        dir_o, step_o, idx_o, err_o, vv_o;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    quad_decoder #(
      .WIDTH      (W),
      .FILTER_LEN (FL),
      .MODE       ((g == 1) ? 1 : ((g == 2) ? 0 : 2)),
      .INDEX_CLEAR((g == 3) ? 0 : 1),
      .VEL_WINDOW (VW)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .inA       (inA),
      .inB       (inB),
      .inZ       (inZ),
      .clear     (clear),
      .err_clr   (err_clr),
      .count     (cnt_o[g]),
      .direction (dir_o[g]),
      .step      (step_o[g]),
      .index_seen(idx_o[g]),
      .error     (err_o[g]),
      .velocity  (vel_o[g]),
      .vel_valid (vv_o[g])
    );
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nstep[4] = '{0, 0, 0, 0};

  // Model state
  logic [1:0]        m_ab;
  logic              m_z, m_dir, m_err;
  logic [3:0][W-1:0] m_count;
  logic [3:0]        m_idx;
  int                m_acc[4];
  int                m_steps[4];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (step_o[i] === 1'b1) nstep[i]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int mode_of(input int i);
    return (i == 1) ? 1 : ((i == 2) ? 0 : 2);
  endfunction

  // Position on the forward gray cycle 00 -> 10 -> 11 -> 01
  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray(input int k);
    case (k % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic bit counts(input int mode, input logic [1:0] o, input logic [1:0] n);
    if (mode == 2) return 1'b1;
    if (mode == 1) return o[1] != n[1];
    return !o[1] && n[1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_step(input logic [1:0] ab, input logic z, input logic clr);
    int d;
    int dd;
    d = (gidx(ab) - gidx(m_ab) + 4) % 4;
    if (d == 2) begin
      m_err = 1'b1;
    end else if (d != 0) begin
      m_dir = (d == 3);
      dd = (d == 1) ? 1 : -1;
      for (int i = 0; i < 4; i++) begin
        if (counts(mode_of(i), m_ab, ab)) begin
          m_count[i] = m_count[i] + W'(dd);
          m_acc[i] += dd;
          m_steps[i]++;
        end
      end
    end
    if (z && !m_z) begin
      for (int i = 0; i < 4; i++) begin
        m_idx[i] = 1'b1;
        if (i != 3) m_count[i] = '0;
      end
    end
    if (clr) begin
      m_count = '0;
      m_idx = '0;
    end
    m_ab = ab;
    m_z = z;
  endtask

  task automatic apply(input logic [1:0] ab, input logic z, input logic clr, input int hold);
    inA = ab[1];
    inB = ab[0];
    inZ = z;
    clear = clr;
    repeat (hold) tick();
    clear = 1'b0;
    model_step(ab, z, clr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inA = 1'b0; inB = 1'b0; inZ = 1'b0; clear = 1'b0; err_clr = 1'b0;
    tick();
    reset = 1'b0;
    cyc = 0;
    m_ab = 2'b00; m_z = 1'b0; m_dir = 1'b0; m_err = 1'b0;
    m_count = '0; m_idx = '0;
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0;
      m_steps[i] = nstep[i];
    end
  endtask

  task automatic test_reset();
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({cnt_o[i], dir_o[i], step_o[i], idx_o[i], err_o[i], vel_o[i], vv_o[i]} !== 37'b0) begin
        bad++;
        $display("FAIL reset inst%0d got cnt=%h dir=%b step=%b idx=%b err=%b vel=%h vv=%b want all 0",
                 i, cnt_o[i], dir_o[i], step_o[i], idx_o[i], err_o[i], vel_o[i], vv_o[i]);
      end
    end
  endtask

  task automatic test_x4_forward();
    do_reset();
    inA = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) begin
        total++;
        if (cnt_o[0] !== 16'd0) begin
          bad++;
          $display("FAIL latency_early got=%h want=0000", cnt_o[0]);
        end
      end
      if (k == 7) begin
        total++;
        if (cnt_o[0] !== 16'd1 || step_o[0] !== 1'b1) begin
          bad++;
          $display("FAIL latency got cnt=%h step=%b want cnt=0001 step=1", cnt_o[0], step_o[0]);
        end
      end
    end
    model_step(2'b10, 1'b0, 1'b0);
    apply(2'b11, 1'b0, 1'b0, 10);
    apply(2'b01, 1'b0, 1'b0, 10);
    apply(2'b00, 1'b0, 1'b0, 10);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cnt_o[i] !== m_count[i] || dir_o[i] !== m_dir || nstep[i] !== m_steps[i]) begin
        bad++;
        $display("FAIL fwd_cycle inst%0d got cnt=%h dir=%b steps=%0d want cnt=%h dir=%b steps=%0d",
                 i, cnt_o[i], dir_o[i], nstep[i], m_count[i], m_dir, m_steps[i]);
      end
    end
    total++;
    if (cnt_o[0] !== 16'd4 || cnt_o[1] !== 16'd2 || cnt_o[2] !== 16'd1) begin
      bad++;
      $display("FAIL mode_counts got x4=%h x2=%h x1=%h want 4/2/1", cnt_o[0], cnt_o[1], cnt_o[2]);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    inA = 1'b1;
    repeat (3) tick();
    inA = 1'b0;
    repeat (12) tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cnt_o[i] !== 16'd0 || nstep[i] !== m_steps[i]) begin
        bad++;
        $display("FAIL glitch3 inst%0d got cnt=%h steps=%0d want cnt=0000 steps=%0d",
                 i, cnt_o[i], nstep[i], m_steps[i]);
      end
    end
    inA = 1'b1;
    repeat (4) tick();
    inA = 1'b0;
    model_step(2'b10, 1'b0, 1'b0);
    repeat (12) tick();
    model_step(2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cnt_o[i] !== m_count[i] || dir_o[i] !== m_dir || nstep[i] !== m_steps[i]) begin
        bad++;
        $display("FAIL pulse4 inst%0d got cnt=%h dir=%b steps=%0d want cnt=%h dir=%b steps=%0d",
                 i, cnt_o[i], dir_o[i], nstep[i], m_count[i], m_dir, m_steps[i]);
      end
    end
  endtask

  task automatic test_reverse_wrap();
    do_reset();
    apply(2'b01, 1'b0, 1'b0, 10);
    total++;
    if (cnt_o[0] !== 16'hFFFF || dir_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL wrap_down got cnt=%h dir=%b want cnt=ffff dir=1", cnt_o[0], dir_o[0]);
    end
    apply(2'b00, 1'b0, 1'b0, 10);
    total++;
    if (cnt_o[0] !== 16'h0000 || dir_o[0] !== 1'b0) begin
      bad++;
      $display("FAIL wrap_up got cnt=%h dir=%b want cnt=0000 dir=0", cnt_o[0], dir_o[0]);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cnt_o[i] !== m_count[i]) begin
        bad++;
        $display("FAIL wrap_model inst%0d got=%h want=%h", i, cnt_o[i], m_count[i]);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    apply(2'b10, 1'b0, 1'b0, 10);
    apply(2'b01, 1'b0, 1'b0, 10);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (err_o[i] !== 1'b1 || cnt_o[i] !== m_count[i] || dir_o[i] !== m_dir) begin
        bad++;
        $display("FAIL illegal inst%0d got err=%b cnt=%h dir=%b want err=1 cnt=%h dir=%b",
                 i, err_o[i], cnt_o[i], dir_o[i], m_count[i], m_dir);
      end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err = 1'b0;
    tick();
    total++;
    if (err_o !== 4'b0000) begin
      bad++;
      $display("FAIL err_clr got=%b want=0000", err_o);
    end
    apply(2'b10, 1'b0, 1'b0, 10);
    // err_clr held across the arrival of another illegal transition
    err_clr = 1'b1;
    inA = 1'b0;
    inB = 1'b1;
    repeat (7) tick();
    err_clr = 1'b0;
    total++;
    if (err_o !== 4'b1111) begin
      bad++;
      $display("FAIL err_clr_vs_illegal got=%b want=1111", err_o);
    end
    repeat (3) tick();
    model_step(2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_index();
    do_reset();
    apply(2'b10, 1'b0, 1'b0, 10);
    apply(2'b11, 1'b0, 1'b0, 10);
    apply(2'b01, 1'b1, 1'b0, 10);
    total++;
    if (cnt_o[0] !== 16'd0 || idx_o[0] !== 1'b1 || cnt_o[3] !== 16'd3 || step_o !== 4'b0000) begin
      bad++;
      $display("FAIL index_zero got cnt=%h idx=%b noidx_cnt=%h want cnt=0000 idx=1 noidx_cnt=0003",
               cnt_o[0], idx_o[0], cnt_o[3]);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cnt_o[i] !== m_count[i] || idx_o[i] !== m_idx[i] || dir_o[i] !== m_dir) begin
        bad++;
        $display("FAIL index_model inst%0d got cnt=%h idx=%b dir=%b want cnt=%h idx=%b dir=%b",
                 i, cnt_o[i], idx_o[i], dir_o[i], m_count[i], m_idx[i], m_dir);
      end
    end
    apply(2'b00, 1'b0, 1'b0, 10);
    apply(2'b10, 1'b1, 1'b1, 10);
    total++;
    if (cnt_o !== '0 || idx_o !== 4'b0000) begin
      bad++;
      $display("FAIL clear_over_index got cnt=%h idx=%b want cnt=0 idx=0000", cnt_o, idx_o);
    end
    apply(2'b11, 1'b1, 1'b0, 10);
    apply(2'b00, 1'b1, 1'b0, 10);
    inA = 1'b1;
    repeat (3) tick();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({cnt_o[i], dir_o[i], step_o[i], idx_o[i], err_o[i], vel_o[i], vv_o[i]} !== 37'b0) begin
        bad++;
        $display("FAIL mid_reset inst%0d got cnt=%h dir=%b idx=%b err=%b want all 0",
                 i, cnt_o[i], dir_o[i], idx_o[i], err_o[i]);
      end
    end
  endtask

  task automatic test_velocity();
    int pulses;
    do_reset();
    for (int k = 0; k < 10; k++) apply(gray(gidx(m_ab) + 1), 1'b0, 1'b0, 7);
    for (int k = 0; k < 3; k++) apply(gray(gidx(m_ab) + 3), 1'b0, 1'b0, 7);
    while (vv_o[0] !== 1'b1 && cyc < 150) tick();
    total++;
    if (cyc != 100 || vv_o !== 4'b1111 || vel_o[0] !== 16'd7) begin
      bad++;
      $display("FAIL vel_window got cyc=%0d vv=%b vel=%h want cyc=100 vv=1111 vel=0007",
               cyc, vv_o, vel_o[0]);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (vel_o[i] !== W'(m_acc[i])) begin
        bad++;
        $display("FAIL vel_model inst%0d got=%h want=%h", i, vel_o[i], W'(m_acc[i]));
      end
      m_acc[i] = 0;
    end
    pulses = 0;
    tick();
    while (cyc < 200) begin
      if (vv_o[0] === 1'b1) pulses++;
      tick();
    end
    total++;
    if (pulses != 0 || vv_o[0] !== 1'b1 || vel_o !== '0) begin
      bad++;
      $display("FAIL vel_idle got extra_pulses=%0d vv=%b vel=%h want 0/1/0", pulses, vv_o[0], vel_o);
    end
  endtask

  task automatic test_random();
    int r;
    logic [1:0] nxt;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       nxt = gray(gidx(m_ab) + 1);
      else if (r < 8)  nxt = gray(gidx(m_ab) + 3);
      else if (r == 8) nxt = m_ab ^ 2'b11;
      else             nxt = m_ab;
      apply(nxt, 1'b0, 1'b0, $urandom_range(8, 14));
      for (int i = 0; i < 4; i++) begin
        total++;
        if (cnt_o[i] !== m_count[i] || dir_o[i] !== m_dir || err_o[i] !== m_err) begin
          bad++;
          $display("FAIL random n=%0d inst%0d got cnt=%h dir=%b err=%b want cnt=%h dir=%b err=%b",
                   n, i, cnt_o[i], dir_o[i], err_o[i], m_count[i], m_dir, m_err);
        end
      end
      if (m_err && $urandom_range(0, 2) == 0) begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_x4_forward();
    test_glitch();
    test_reverse_wrap();
    test_illegal();
    test_index();
    test_velocity();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
